// File: rtl/dense_layer_seq_if.sv
// Handshake and data bus of the time-multiplexed dense layer.
// The master drives the request and operands; the slave returns status and results.
interface dense_layer_seq_if #(
    parameter int unsigned N_IN  = 7,
    parameter int unsigned N_OUT = 128,
    parameter int unsigned IN_W  = 4,
    parameter int unsigned W_W   = 9,
    parameter int unsigned OUT_W = 9
);
    logic                        start;
    logic [N_IN*IN_W-1:0]        inputs;
    logic [N_IN*N_OUT*W_W-1:0]   weights;
    logic [N_OUT*W_W-1:0]        biases;
    logic                        busy;
    logic                        done;
    logic [N_OUT*OUT_W-1:0]      result;
    logic                        sat_flag;

    modport master (
        output start, inputs, weights, biases,
        input  busy, done, result, sat_flag
    );

    modport slave (
        input  start, inputs, weights, biases,
        output busy, done, result, sat_flag
    );
endinterface

// File: rtl/dense_layer_seq.sv
// Fully-connected layer evaluated group by group with LANES parallel MACs:
// result[i] = sat(((sum_j x[j]*w[j][i]) + b[i]) >>> SHIFT), optional ReLU.
module dense_layer_seq #(
    parameter int unsigned N_IN  = 7,
    parameter int unsigned N_OUT = 128,
    parameter int unsigned IN_W  = 4,
    parameter int unsigned W_W   = 9,
    parameter int unsigned ACC_W = 30,
    parameter int unsigned SHIFT = 9,
    parameter int unsigned OUT_W = 9,
    parameter int unsigned LANES = 8,
    parameter int unsigned RELU  = 0
) (
    input  logic              clk,
    input  logic              rst,
    dense_layer_seq_if.slave  bus
);
    localparam int unsigned G  = N_OUT / LANES;
    localparam int unsigned JW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;
    localparam int unsigned PW = IN_W + W_W;
    localparam int unsigned SW = ACC_W + 1;
    localparam logic signed [SW-1:0] R_MAX = SW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] R_MIN = ~R_MAX;

    typedef enum logic [1:0] {IDLE, MAC, BIAS, DONE} state_t;

    state_t                   state, state_n;
    logic [N_IN*IN_W-1:0]     x_q;
    logic signed [ACC_W-1:0]  acc [LANES];
    logic [JW-1:0]            j_q;
    logic [GW-1:0]            g_q;
    logic [N_OUT*OUT_W-1:0]   result_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     sat_q;

    logic signed [IN_W-1:0]   x_cur;
    logic signed [W_W-1:0]    w_cur    [LANES];
    logic signed [W_W-1:0]    b_cur    [LANES];
    logic signed [PW-1:0]     prod     [LANES];
    logic signed [SW-1:0]     biased   [LANES];
    logic signed [SW-1:0]     shifted  [LANES];
    logic signed [OUT_W-1:0]  lane_res [LANES];
    logic [LANES-1:0]         lane_sat;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = MAC;
            MAC:     if (j_q == JW'(N_IN - 1)) state_n = BIAS;
            BIAS:    state_n = (g_q == GW'(G - 1)) ? DONE : MAC;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Per-lane product, bias add, floor shift, saturation and optional ReLU
    always_comb begin
        x_cur    = x_q[int'(j_q)*IN_W +: IN_W];
        lane_sat = '0;
        for (int l = 0; l < LANES; l++) begin
            w_cur[l]   = bus.weights[(int'(j_q)*N_OUT + int'(g_q)*LANES + l)*W_W +: W_W];
            b_cur[l]   = bus.biases[(int'(g_q)*LANES + l)*W_W +: W_W];
            prod[l]    = PW'(x_cur) * PW'(w_cur[l]);
            biased[l]  = SW'(acc[l]) + SW'(b_cur[l]);
            shifted[l] = biased[l] >>> SHIFT;
            lane_res[l] = shifted[l][OUT_W-1:0];
            if (shifted[l] > R_MAX) begin
                lane_res[l] = OUT_W'(R_MAX);
                lane_sat[l] = 1'b1;
            end else if (shifted[l] < R_MIN) begin
                lane_res[l] = OUT_W'(R_MIN);
                lane_sat[l] = 1'b1;
            end
            // ReLU clamp happens after saturation and never flags saturation
            if ((RELU != 0) && lane_res[l][OUT_W-1]) lane_res[l] = '0;
        end
    end

    // Datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q      <= '0;
            j_q      <= '0;
            g_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sat_q    <= 1'b0;
            for (int l = 0; l < LANES; l++) acc[l] <= '0;
        end else begin
            busy_q <= (state_n == MAC) || (state_n == BIAS);
            done_q <= (state_n == DONE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        x_q   <= bus.inputs;
                        j_q   <= '0;
                        g_q   <= '0;
                        sat_q <= 1'b0;
                        for (int l = 0; l < LANES; l++) acc[l] <= '0;
                    end
                end
                MAC: begin
                    for (int l = 0; l < LANES; l++) acc[l] <= acc[l] + ACC_W'(prod[l]);
                    j_q <= j_q + JW'(1);
                end
                BIAS: begin
                    for (int l = 0; l < LANES; l++) begin
                        result_q[(int'(g_q)*LANES + l)*OUT_W +: OUT_W] <= lane_res[l];
                        acc[l] <= '0;
                    end
                    sat_q <= sat_q | (|lane_sat);
                    j_q   <= '0;
                    if (g_q != GW'(G - 1)) g_q <= g_q + GW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.sat_flag = sat_q;
endmodule
